// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks.
//   PARITY_* : parity-mode encodings used by the parity_mode parameter
//   tx_state_t : bit-timing engine states
//   calc_parity : parity bit for a (zero-extended) data word
package uart_pkg;

    localparam int PARITY_NONE = 32'sd0;
    localparam int PARITY_EVEN = 32'sd1;
    localparam int PARITY_ODD  = 32'sd2;

    // Widest payload any frame may carry; callers zero-extend to this width.
    localparam int MAX_DATA_BITS = 32'sd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } tx_state_t;

    // Even parity is the XOR of the data bits, odd its inverse. Unused
    // upper bits must be zero so they do not disturb the result.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int mode);
        logic x_s;
        logic res_s;
        x_s = ^data;
        case (mode)
            PARITY_EVEN: res_s = x_s;
            PARITY_ODD:  res_s = ~x_s;
            default:     res_s = 1'b0;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO shared by the UART transmitter and receiver.
//   clk, rst : clock, asynchronous active-high reset
//   push, wdata : write strobe and word (ignored while full)
//   pop, rdata  : read strobe (ignored while empty); rdata shows the head word
//   full, empty, count : status, combinational from the registered pointers
module uart_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         wdata,
    output logic [width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers are one bit wider than the address so full and empty differ
    // only in the wrap bit.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [width-1:0] mem_r [depth];
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a transmit FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   i_data, i_req : word to send and write request (taken while o_cts is 1)
//   o_serial : serial line, idle high, straight from a register
//   o_cts    : FIFO not full
//   o_idle   : FIFO empty and no frame on the line
//   o_count  : FIFO occupancy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 4,
    parameter int data_bits      = 8,
    parameter int parity_mode    = 0,
    parameter int stop_bits      = 1,
    parameter int gap_bits       = 0,
    parameter int fifo_depth     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [data_bits-1:0]          i_data,
    input  logic                          i_req,
    output logic                          o_serial,
    output logic                          o_cts,
    output logic                          o_idle,
    output logic [$clog2(fifo_depth):0]   o_count
);

    localparam int CNT_W = $clog2(cycles_per_bit);
    localparam int MAX_DS = (data_bits > stop_bits) ? data_bits : stop_bits;
    localparam int MAX_PHASE = (MAX_DS > gap_bits) ? MAX_DS : gap_bits;
    localparam int IDX_W = (MAX_PHASE > 32'sd1) ? $clog2(MAX_PHASE) : 32'sd1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(cycles_per_bit - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(data_bits - 32'sd1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(stop_bits - 32'sd1);
    localparam logic [IDX_W-1:0] GAP_LAST  =
        IDX_W'((gap_bits > 32'sd0) ? gap_bits - 32'sd1 : 32'sd0);
    localparam bit HAS_PARITY = (parity_mode != PARITY_NONE);
    localparam bit HAS_GAP    = (gap_bits > 32'sd0);

    tx_state_t            state_r, state_s;
    logic [CNT_W-1:0]     cyc_r, cyc_s;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [data_bits-1:0] shift_r, shift_s;
    logic                 par_r, par_s;
    logic                 serial_r, serial_s;
    logic                 bit_done_s;
    logic                 free_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [data_bits-1:0] fifo_rdata_s;

    assign push_s   = i_req && !fifo_full_s;
    assign o_cts    = !fifo_full_s;
    assign o_serial = serial_r;
    assign o_idle   = fifo_empty_s && (state_r == ST_IDLE);

    uart_fifo #(
        .width (data_bits),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (i_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (o_count)
    );

    // Next-state logic for the bit-timing engine.
    always_comb begin
        state_s    = state_r;
        cyc_s      = cyc_r;
        idx_s      = idx_r;
        shift_s    = shift_r;
        par_s      = par_r;
        serial_s   = serial_r;
        pop_s      = 1'b0;
        free_s     = 1'b0;
        bit_done_s = (cyc_r == CNT_ZERO);

        case (state_r)
            ST_IDLE: begin
                free_s = 1'b1;
            end
            ST_START: begin
                if (!bit_done_s) begin
                    cyc_s = cyc_r - CNT_ONE;
                end else begin
                    state_s  = ST_DATA;
                    cyc_s    = CNT_LOAD;
                    idx_s    = DATA_LAST;
                    serial_s = shift_r[0];
                    shift_s  = {1'b0, shift_r[data_bits-1:1]};
                end
            end
            ST_DATA: begin
                if (!bit_done_s) begin
                    cyc_s = cyc_r - CNT_ONE;
                end else if (idx_r != IDX_ZERO) begin
                    idx_s    = idx_r - IDX_ONE;
                    cyc_s    = CNT_LOAD;
                    serial_s = shift_r[0];
                    shift_s  = {1'b0, shift_r[data_bits-1:1]};
                end else if (HAS_PARITY) begin
                    state_s  = ST_PARITY;
                    cyc_s    = CNT_LOAD;
                    serial_s = par_r;
                end else begin
                    state_s  = ST_STOP;
                    cyc_s    = CNT_LOAD;
                    idx_s    = STOP_LAST;
                    serial_s = 1'b1;
                end
            end
            ST_PARITY: begin
                if (!bit_done_s) begin
                    cyc_s = cyc_r - CNT_ONE;
                end else begin
                    state_s  = ST_STOP;
                    cyc_s    = CNT_LOAD;
                    idx_s    = STOP_LAST;
                    serial_s = 1'b1;
                end
            end
            ST_STOP: begin
                if (!bit_done_s) begin
                    cyc_s = cyc_r - CNT_ONE;
                end else if (idx_r != IDX_ZERO) begin
                    idx_s = idx_r - IDX_ONE;
                    cyc_s = CNT_LOAD;
                end else if (HAS_GAP) begin
                    state_s = ST_GAP;
                    cyc_s   = CNT_LOAD;
                    idx_s   = GAP_LAST;
                end else begin
                    free_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (!bit_done_s) begin
                    cyc_s = cyc_r - CNT_ONE;
                end else if (idx_r != IDX_ZERO) begin
                    idx_s = idx_r - IDX_ONE;
                    cyc_s = CNT_LOAD;
                end else begin
                    free_s = 1'b1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                serial_s = 1'b1;
            end
        endcase

        // When the engine is free, the head word launches on this same edge
        // so back-to-back frames have no idle cycle between them.
        if (free_s && !fifo_empty_s) begin
            pop_s    = 1'b1;
            state_s  = ST_START;
            cyc_s    = CNT_LOAD;
            shift_s  = fifo_rdata_s;
            par_s    = calc_parity(MAX_DATA_BITS'(fifo_rdata_s), parity_mode);
            serial_s = 1'b0;
        end else if (free_s) begin
            state_s  = ST_IDLE;
            serial_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Engine state registers; reset abandons any frame and drives the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cyc_r    <= CNT_ZERO;
            idx_r    <= IDX_ZERO;
            shift_r  <= {data_bits{1'b0}};
            par_r    <= 1'b0;
            serial_r <= 1'b1;
        end else begin
            state_r  <= state_s;
            cyc_r    <= cyc_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            par_r    <= par_s;
            serial_r <= serial_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three transmitter configurations driven in parallel; a per-edge reference
// model predicts FIFO occupancy and frame start times, and a line monitor
// decodes each frame and compares it against the queued expectation.
module tb_uart_tx_fifo;

    localparam int N = 3;
    localparam int CPB   [N] = '{4, 3, 2};
    localparam int DB    [N] = '{8, 7, 9};
    localparam int PM    [N] = '{0, 2, 1};
    localparam int SB    [N] = '{1, 2, 1};
    localparam int GB    [N] = '{0, 3, 1};
    localparam int DEPTH [N] = '{4, 4, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req_s;
    logic [7:0] din0_s;
    logic [6:0] din1_s;
    logic [8:0] din2_s;
    logic [2:0] ser_s, cts_s, idle_s;
    logic [2:0] cnt0_s, cnt1_s;
    logic [1:0] cnt2_s;

    always #5 clk = ~clk;

    uart_tx_fifo #(.cycles_per_bit(CPB[0]), .data_bits(DB[0]), .parity_mode(PM[0]),
                   .stop_bits(SB[0]), .gap_bits(GB[0]), .fifo_depth(DEPTH[0])) dut0 (
        .clk(clk), .rst(rst), .i_data(din0_s), .i_req(req_s[0]),
        .o_serial(ser_s[0]), .o_cts(cts_s[0]), .o_idle(idle_s[0]), .o_count(cnt0_s));

    uart_tx_fifo #(.cycles_per_bit(CPB[1]), .data_bits(DB[1]), .parity_mode(PM[1]),
                   .stop_bits(SB[1]), .gap_bits(GB[1]), .fifo_depth(DEPTH[1])) dut1 (
        .clk(clk), .rst(rst), .i_data(din1_s), .i_req(req_s[1]),
        .o_serial(ser_s[1]), .o_cts(cts_s[1]), .o_idle(idle_s[1]), .o_count(cnt1_s));

    uart_tx_fifo #(.cycles_per_bit(CPB[2]), .data_bits(DB[2]), .parity_mode(PM[2]),
                   .stop_bits(SB[2]), .gap_bits(GB[2]), .fifo_depth(DEPTH[2])) dut2 (
        .clk(clk), .rst(rst), .i_data(din2_s), .i_req(req_s[2]),
        .o_serial(ser_s[2]), .o_cts(cts_s[2]), .o_idle(idle_s[2]), .o_count(cnt2_s));

    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    bit         final_chk = 1'b0;

    // Reference model and scoreboard state, one slot per configuration.
    int         m_cnt   [N];
    int         free_at [N];
    logic [8:0] word_q  [N][$];
    int         fq_start[N][$];
    logic [8:0] fq_word [N][$];
    bit         in_frame[N];
    int         pos     [N];
    int         ferr    [N];
    logic [8:0] cur_word[N];

    function automatic int frame_len(input int i);
        return CPB[i] * (1 + DB[i] + ((PM[i] != 0) ? 1 : 0) + SB[i] + GB[i]);
    endfunction

    function automatic logic [8:0] mask_word(input int i, input logic [8:0] w);
        logic [8:0] m;
        m = (9'd1 << DB[i]) - 9'd1;
        if (DB[i] == 9) m = 9'h1FF;
        return w & m;
    endfunction

    // Line level expected at cycle p of a frame carrying word w.
    function automatic logic exp_level(input int i, input logic [8:0] w, input int p);
        int         b;
        logic [8:0] m;
        b = p / CPB[i];
        m = mask_word(i, w);
        if (b == 0) return 1'b0;
        if (b <= DB[i]) return m[b-1];
        if (PM[i] != 0 && b == DB[i] + 1) return (PM[i] == 2) ? ~(^m) : (^m);
        return 1'b1;
    endfunction

    function automatic logic [8:0] get_din(input int i);
        if (i == 0) return {1'b0, din0_s};
        if (i == 1) return {2'b00, din1_s};
        return din2_s;
    endfunction

    function automatic int get_cnt(input int i);
        if (i == 0) return int'(cnt0_s);
        if (i == 1) return int'(cnt1_s);
        return int'(cnt2_s);
    endfunction

    task automatic chk(input bit ok, input string name, input int i,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d edge %0d: got %0d, want %0d",
                     name, i, edge_n, act, exp);
        end
    endtask

    // Monitor and model: check the state left by the last edge, then
    // advance the model for the coming edge using the inputs now applied.
    always @(negedge clk) begin
        bit         exp_start;
        bit         pop_b, push_b;
        logic [8:0] w;
        int         e1;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                chk(ser_s[i] == 1'b1, "rst_serial", i, int'(ser_s[i]), 1);
                chk(get_cnt(i) == 0, "rst_count", i, get_cnt(i), 0);
                chk(cts_s[i] == 1'b1, "rst_cts", i, int'(cts_s[i]), 1);
                chk(idle_s[i] == 1'b1, "rst_idle", i, int'(idle_s[i]), 1);
                m_cnt[i]   = 0;
                free_at[i] = 0;
                in_frame[i] = 1'b0;
                word_q[i].delete();
                fq_start[i].delete();
                fq_word[i].delete();
            end else begin
                chk(get_cnt(i) == m_cnt[i], "count", i, get_cnt(i), m_cnt[i]);
                chk(cts_s[i] == (m_cnt[i] < DEPTH[i]), "cts", i, int'(cts_s[i]),
                    (m_cnt[i] < DEPTH[i]) ? 1 : 0);
                chk(idle_s[i] == (m_cnt[i] == 0 && edge_n >= free_at[i]), "idle", i,
                    int'(idle_s[i]), (m_cnt[i] == 0 && edge_n >= free_at[i]) ? 1 : 0);

                if (!in_frame[i]) begin
                    exp_start = (fq_start[i].size() > 0) ? (fq_start[i][0] <= edge_n) : 1'b0;
                    if (ser_s[i] == 1'b0 || exp_start) begin
                        if (fq_start[i].size() > 0) begin
                            chk(ser_s[i] == 1'b0 && fq_start[i][0] == edge_n, "frame_start", i,
                                (ser_s[i] == 1'b0) ? edge_n : -1, fq_start[i][0]);
                            void'(fq_start[i].pop_front());
                            cur_word[i] = fq_word[i].pop_front();
                        end else begin
                            chk(fq_start[i].size() > 0, "unexpected_start", i, edge_n, -1);
                            cur_word[i] = 9'h000;
                        end
                        if (ser_s[i] == 1'b0) begin
                            in_frame[i] = 1'b1;
                            pos[i]      = 0;
                            ferr[i]     = 0;
                        end
                    end
                end else begin
                    pos[i]++;
                    if (ser_s[i] !== exp_level(i, cur_word[i], pos[i])) ferr[i]++;
                    if (pos[i] == frame_len(i) - 1) begin
                        chk(ferr[i] == 0, "frame_bits", i, ferr[i], 0);
                        in_frame[i] = 1'b0;
                    end
                end

                if (final_chk) begin
                    chk(fq_start[i].size() == 0 && word_q[i].size() == 0 && !in_frame[i],
                        "drained", i, fq_start[i].size() + word_q[i].size(), 0);
                end

                e1     = edge_n + 1;
                pop_b  = (m_cnt[i] > 0) && (e1 >= free_at[i]);
                push_b = req_s[i] && (m_cnt[i] < DEPTH[i]);
                if (pop_b) begin
                    w = word_q[i].pop_front();
                    fq_start[i].push_back(e1);
                    fq_word[i].push_back(w);
                    free_at[i] = e1 + frame_len(i);
                end
                if (push_b) word_q[i].push_back(mask_word(i, get_din(i)));
                m_cnt[i] = m_cnt[i] + (push_b ? 1 : 0) - (pop_b ? 1 : 0);
            end
        end
        edge_n++;
    end

    // One edge with the given requests and data, then return just after it.
    task automatic drive(input logic [2:0] r, input logic [8:0] d0,
                         input logic [8:0] d1, input logic [8:0] d2);
        req_s  = r;
        din0_s = d0[7:0];
        din1_s = d1[6:0];
        din2_s = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        req_s = 3'b000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        req_s  = 3'b000;
        din0_s = 8'h00;
        din1_s = 7'h00;
        din2_s = 9'h000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single words: 8N1 0x55, odd parity 0x07, even parity 0x07.
        drive(3'b111, 9'h055, 9'h007, 9'h007);
        idle_cycles(80);
        // 7-bit word with two stop bits and a gap.
        drive(3'b010, 9'h000, 9'h07F, 9'h000);
        idle_cycles(60);

        // Fill past capacity: values 1..6 on consecutive edges.
        for (int v = 1; v <= 6; v++) drive(3'b111, 9'(v), 9'(v), 9'(v));
        idle_cycles(260);

        // Random traffic, deliberately ignoring o_cts sometimes.
        repeat (300) begin
            drive(3'($urandom_range(0, 7)), 9'($urandom), 9'($urandom), 9'($urandom));
        end
        idle_cycles(300);

        // Reset in the middle of data bit 3 of 0xA5 with words still queued.
        drive(3'b111, 9'h0A5, 9'h025, 9'h1A5);
        drive(3'b111, 9'h011, 9'h012, 9'h013);
        drive(3'b111, 9'h021, 9'h022, 9'h023);
        idle_cycles(16);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        drive(3'b111, 9'h03C, 9'h03C, 9'h03C);
        idle_cycles(100);

        final_chk = 1'b1;
        @(posedge clk);
        #1 final_chk = 1'b0;
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Data width, parity mode, stop-bit count and inter-frame gap are configurable. A small transmit FIFO decouples the producer from the bit-timing engine. It sits between a byte-producing client (CPU bus bridge or test pattern source) and the external serial pin, and streams queued words back-to-back without producer involvement.

## Interface
Parameters:
- `cycles_per_bit`, 4: clock cycles per serial bit; must be ≥ 2.
- `data_bits`, 8: payload bits per frame; legal range 5–9.
- `parity_mode`, 0: 0 = none, 1 = even, 2 = odd.
- `stop_bits`, 1: stop bits per frame; legal values 1 or 2.
- `gap_bits`, 0: extra idle-high bit times after the stop bits of every frame.
- `fifo_depth`, 4: number of queued words; power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `i_data` in `data_bits`: word to transmit.
- `i_req` in 1: write request; accepted when `o_cts` is 1.
- `o_serial` out 1: serial line, idle high.
- `o_cts` out 1: FIFO not full.
- `o_idle` out 1: FIFO empty and no frame in progress.
- `o_count` out `$clog2(fifo_depth)+1`: FIFO occupancy.

## Operation
- **Reset values** (immediate on `rst`, no clock needed):
  - `o_serial` = 1, `o_cts` = 1, `o_idle` = 1, `o_count` = 0.
  - FIFO pointers cleared. A frame in progress is abandoned; the line goes high.
- **Write:** a word is written on every edge where `i_req` && `o_cts`. `i_req` while full is ignored and the word is dropped; the producer must honour `o_cts`.
- **Engine FSM:**
  - IDLE → START when the FIFO is non-empty. The head word pops into the shift register on that same edge.
  - START → DATA, shifting LSB first, `data_bits` bits.
  - DATA → PARITY if `parity_mode` ≠ 0, else → STOP.
  - PARITY → STOP (`stop_bits` bits) → GAP (`gap_bits` bits; skipped if 0) → IDLE.
- **Bit levels:**
  - Start bit is 0. Stop and gap bits are 1.
  - Parity bit: even = XOR of data bits; odd = its inverse.
- **Counters:**
  - Bit-cycle counter counts `cycles_per_bit`-1 down to 0; each state bit holds `o_serial` for exactly `cycles_per_bit` cycles.
  - Bit-index counter is sized by `$clog2` of the longest phase. No arithmetic may wrap below 0.
- **Back-to-back:** when the last stop/gap bit ends and the FIFO is non-empty, the engine passes through IDLE for zero cycles: the next start bit begins on the edge after the last gap/stop cycle.
- **Simultaneous push and pop:**
  - Occupancy unchanged; a push when full with a simultaneous pop is still refused, because `o_cts` is registered from the current count.
  - Push into an empty FIFO is not bypassed to the engine.
- **`o_idle`** is 0 from the edge that accepts a write until the last stop/gap cycle completes with the FIFO empty.

## Timing
- **Latency:** write accepted at edge k with engine idle → `o_serial` falls after edge k+1.
- **Frame length:** `cycles_per_bit`·(1 + `data_bits` + (parity≠0) + `stop_bits` + `gap_bits`) cycles. Consecutive frames have no additional idle cycles.
- **`o_cts` and `o_count`** update on the edge after a push or pop; they are combinational from registered pointers only.
- **`o_serial`** is driven directly from a register; there is no combinational path from inputs.

## Structure
- **Shared package `uart_pkg`:**
  - Parity-mode constants `PARITY_NONE`/`PARITY_EVEN`/`PARITY_ODD`.
  - Engine state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP, GAP).
- **Sub-module `uart_fifo`:**
  - Parameters `width` and `depth`.
  - Ports: push, pop, data, full, empty, count.
  - Pointers carry an extra wrap bit for full/empty.
  - Reusable by the matching receiver.
- **Top level** holds the engine FSM, counters and shift register.

## Test plan
- **8N1 single word:** `cycles_per_bit`=4, 8N1, write 0x55.
  - `o_serial` = 0, 1,0,1,0,1,0,1,0, 1, each held 4 cycles (40 total).
  - `o_idle` returns to 1 at cycle 41.
- **Even parity:** `parity_mode`=1, write 0x07 → parity bit 1.
- **Odd parity:** `parity_mode`=2, write 0x07 → parity bit 0. Frame 44 cycles.
- **7-bit with gap:** `data_bits`=7, `stop_bits`=2, `gap_bits`=3, write 0x7F → 0, seven 1s, then five 1s (2 stop + 3 gap); 52 cycles.
- **FIFO fill and overflow:** `fifo_depth`=4, hold `i_req` high for 6 cycles with values 1..6.
  - Words 1–5 accepted: one popped by the engine, four queued; `o_cts` falls after the fifth accept.
  - Word 6 dropped.
  - Five frames sent back-to-back with no idle gap; `o_count` sequence 1,1,2,3,4 then decrements per frame.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xA5.
  - `o_serial`=1 and `o_count`=0 immediately.
  - After release, writing 0x3C sends a clean full frame.
